// File: rtl/amo_arbiter_if.sv
// amo_arbiter_if: requester-side and D$-side AMO buses of the arbiter, plus its status flags.
// Ports: req_i/resp_o per requester, amo_req_o/amo_resp_i towards the D$, busy_o, lock_o.
// Modports: master = requesters and D$ (testbench side), slave = the arbiter itself.
interface amo_arbiter_if #(
  parameter int NR_PORTS = 2
);
  typedef struct packed {
    logic        req;
    logic [3:0]  amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;

  amo_req_t  [NR_PORTS-1:0] req_i;
  amo_resp_t [NR_PORTS-1:0] resp_o;
  amo_req_t                 amo_req_o;
  amo_resp_t                amo_resp_i;
  logic                     busy_o;
  logic                     lock_o;

  modport master (output req_i, amo_resp_i, input resp_o, amo_req_o, busy_o, lock_o);
  modport slave  (input req_i, amo_resp_i, output resp_o, amo_req_o, busy_o, lock_o);
endinterface

// File: rtl/amo_arbiter.sv
// amo_arbiter: round-robin share of one D$ AMO port among NR_PORTS requesters, with an LR exclusive window.
// Ports: clk_i, rst_i (async, active-high), bus (slave: req_i/resp_o, amo_req_o/amo_resp_i, busy_o, lock_o).
// Latency: grant registered 1 cycle after req, ack routed same cycle; one AMO in flight, others wait holding req.
module amo_arbiter #(
  parameter int NR_PORTS       = 2,
  parameter int LR_LOCK_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  amo_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NR_PORTS);
  localparam int CNT_W = $clog2(LR_LOCK_CYCLES + 1);
  localparam logic [3:0]       AMO_LR    = 4'h1;
  localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(LR_LOCK_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;

  logic [IDX_W-1:0] rr_q, g_q, lk_q;
  logic [IDX_W-1:0] win_idx, cand_idx;
  logic             win_vld;
  logic             lock_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  logic [3:0]       op_q;
  logic [1:0]       size_q;
  logic [63:0]      opa_q, opb_q;
  logic             grant, done;

  // First requester at or after rr, wrapping; only the lock owner is eligible while locked.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cand_idx = IDX_W'((int'(rr_q) + i) % NR_PORTS);
      if (!win_vld && bus.req_i[cand_idx].req && (!lock_q || cand_idx == lk_q)) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (win_vld) begin
        grant   = 1'b1;
        state_d = BUSY;
      end
      BUSY: if (bus.amo_resp_i.ack) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      g_q    <= '0;
      lk_q   <= '0;
      lock_q <= 1'b0;
      cnt_q  <= '0;
      req_q  <= 1'b0;
      op_q   <= '0;
      size_q <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
    end else if (grant) begin
      // Counter stays frozen while the lock owner's op is in flight.
      g_q    <= win_idx;
      req_q  <= 1'b1;
      op_q   <= bus.req_i[win_idx].amo_op;
      size_q <= bus.req_i[win_idx].size;
      opa_q  <= bus.req_i[win_idx].operand_a;
      opb_q  <= bus.req_i[win_idx].operand_b;
    end else if (done) begin
      req_q <= 1'b0;
      rr_q  <= IDX_W'((int'(g_q) + 1) % NR_PORTS);
      // Only the lock owner can be granted while locked, so any non-LR ack ends the window.
      if (op_q == AMO_LR) begin
        lk_q   <= g_q;
        lock_q <= 1'b1;
        cnt_q  <= LOCK_INIT;
      end else begin
        lock_q <= 1'b0;
        cnt_q  <= '0;
      end
    end else if (state_q == IDLE && lock_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) lock_q <= 1'b0;
    end
  end

  always_comb begin
    bus.amo_req_o.req       = req_q;
    bus.amo_req_o.amo_op    = op_q;
    bus.amo_req_o.size      = size_q;
    bus.amo_req_o.operand_a = opa_q;
    bus.amo_req_o.operand_b = opb_q;
    for (int k = 0; k < NR_PORTS; k++) begin
      bus.resp_o[k].result = bus.amo_resp_i.result;
      bus.resp_o[k].ack    = (state_q == BUSY) && (g_q == IDX_W'(k)) && bus.amo_resp_i.ack;
    end
  end

  assign bus.busy_o = (state_q == BUSY);
  assign bus.lock_o = lock_q;

endmodule

// File: tb/tb_amo_arbiter.sv
// tb_amo_arbiter: randomized and directed traffic against a spec-level reference model with a scoreboard.
// Ports: none; drives the amo_arbiter_if master side, models requesters and the D$.
// Latency: inputs driven 1 time unit after posedge, outputs checked on negedge.
module tb_amo_arbiter;
  localparam int NP  = 3;
  localparam int LRC = 16;
  localparam logic [3:0] OP_LR = 4'h1, OP_SC = 4'h2, OP_SWAP = 4'h3, OP_ADD = 4'h4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amo_arbiter_if #(.NR_PORTS(NP)) bus ();
  amo_arbiter #(.NR_PORTS(NP), .LR_LOCK_CYCLES(LRC)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  size;
    logic [63:0] a;
    logic [63:0] b;
  } txn_t;

  int checks = 0;
  int errors = 0;

  // stimulus control
  int  go [NP];
  int  op_sel [NP];
  bit  drop_early [NP];
  bit  pend [NP];
  int  seen_cnt [NP];
  int  gap_max;
  int  ds_lat;
  bit  stray;
  bit  ds_out;
  int  ds_wait;
  logic [3:0]  t_op;
  logic [63:0] t_a, t_b;
  logic [63:0] exp_q [NP][$];

  // reference model and monitor state
  bit   m_busy;
  int   m_g, m_rr, m_lk, m_lock_left;
  txn_t m_txn;
  txn_t grant_q [$];
  int   glog [$];
  int   ack_cnt [NP];
  logic prev_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dres(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    return (a ^ {b[31:0], b[63:32]}) + {60'd0, op};
  endfunction

  // ---------------- monitor + reference model ----------------
  always @(negedge clk) begin : mon
    int win;
    int p;
    bit exp_ack;
    if (rst) begin
      chk("rst_amo_req", bus.amo_req_o.req, 1'b0);
      chk("rst_amo_fields", {bus.amo_req_o.amo_op, bus.amo_req_o.operand_a}, '0);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_lock", bus.lock_o, 1'b0);
      for (int k = 0; k < NP; k++) chk("rst_resp", {bus.resp_o[k].ack, bus.resp_o[k].result}, '0);
      m_busy = 0; m_g = 0; m_rr = 0; m_lk = 0; m_lock_left = 0;
      grant_q.delete();
      prev_req = 1'b0;
    end else begin
      if (bus.amo_req_o.req && !prev_req) begin
        if (grant_q.size() == 0) chk("unexpected_issue", 1'b1, 1'b0);
        else begin
          txn_t e;
          e = grant_q.pop_front();
          chk("issue_fields", {bus.amo_req_o.amo_op, bus.amo_req_o.size, bus.amo_req_o.operand_a,
                               bus.amo_req_o.operand_b} >> 64, {e.op, e.size, e.a, e.b} >> 64);
          chk("issue_opb", bus.amo_req_o.operand_b, e.b);
        end
        glog.push_back(int'(bus.amo_req_o.operand_a[63:56]));
      end
      prev_req = bus.amo_req_o.req;

      chk("busy", bus.busy_o, m_busy);
      chk("lock", bus.lock_o, m_lock_left > 0);
      chk("amo_req", bus.amo_req_o.req, m_busy);
      if (m_busy) chk("held_opa", bus.amo_req_o.operand_a, m_txn.a);

      for (int k = 0; k < NP; k++) begin
        exp_ack = m_busy && (m_g == k) && bus.amo_resp_i.ack;
        chk("resp_ack", bus.resp_o[k].ack, exp_ack);
        chk("resp_result", bus.resp_o[k].result, bus.amo_resp_i.result);
        if (bus.resp_o[k].ack) begin
          ack_cnt[k]++;
          if (exp_q[k].size() == 0) chk("ack_no_pending", 1'b1, 1'b0);
          else chk("scoreboard_result", bus.resp_o[k].result, exp_q[k].pop_front());
        end
      end

      // advance the model to the next cycle
      if (m_busy) begin
        if (bus.amo_resp_i.ack) begin
          m_busy = 0;
          m_rr   = (m_g + 1) % NP;
          if (m_txn.op == OP_LR) begin
            m_lk = m_g;
            m_lock_left = LRC;
          end else m_lock_left = 0;
        end
      end else begin
        win = -1;
        for (int i = 0; i < NP; i++) begin
          p = (m_rr + i) % NP;
          if (win < 0 && bus.req_i[p].req && (m_lock_left == 0 || p == m_lk)) win = p;
        end
        if (win >= 0) begin
          m_busy = 1;
          m_g    = win;
          m_txn  = '{op: bus.req_i[win].amo_op, size: bus.req_i[win].size,
                     a: bus.req_i[win].operand_a, b: bus.req_i[win].operand_b};
          grant_q.push_back(m_txn);
        end else if (m_lock_left > 0) m_lock_left--;
      end
    end
  end

  // ---------------- stimulus: requesters and D$ ----------------
  task automatic clear_inputs();
    for (int k = 0; k < NP; k++) begin
      bus.req_i[k] = '0;
      pend[k] = 0;
      go[k] = 0;
      drop_early[k] = 0;
      seen_cnt[k] = ack_cnt[k];
      exp_q[k].delete();
    end
    bus.amo_resp_i = '0;
    ds_out = 0;
    stray = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      clear_inputs();
      return;
    end
    // D$ model
    if (bus.amo_resp_i.ack) begin
      bus.amo_resp_i.ack = 1'b0;
      ds_out = 0;
    end else if (stray) begin
      bus.amo_resp_i.ack = 1'b1;
      bus.amo_resp_i.result = 64'hDEAD;
      stray = 0;
    end else if (bus.amo_req_o.req) begin
      if (!ds_out) begin
        ds_out  = 1;
        ds_wait = (ds_lat < 0) ? int'($urandom_range(0, 4)) : ds_lat;
      end
      if (ds_wait == 0) begin
        bus.amo_resp_i.ack = 1'b1;
        bus.amo_resp_i.result = dres(bus.amo_req_o.amo_op, bus.amo_req_o.operand_a, bus.amo_req_o.operand_b);
      end else ds_wait--;
    end
    // requesters
    for (int k = 0; k < NP; k++) begin
      if (pend[k]) begin
        if (ack_cnt[k] != seen_cnt[k]) begin
          seen_cnt[k] = ack_cnt[k];
          bus.req_i[k].req = 1'b0;
          pend[k] = 0;
        end else if (drop_early[k] && m_busy && m_g == k) begin
          bus.req_i[k].req = 1'b0;
          bus.req_i[k].operand_a = '1;
          bus.req_i[k].operand_b = '0;
          drop_early[k] = 0;
        end
      end else if (go[k] > 0 && $urandom_range(0, gap_max) == 0) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (op_sel[k] >= 0) t_op = 4'(op_sel[k]);
        else t_op = (r < 3) ? OP_LR : (r < 5) ? OP_SC : (r < 7) ? OP_ADD : OP_SWAP;
        t_a = {8'(k), 24'h0, 32'($urandom)};
        t_b = {32'($urandom), 32'($urandom)};
        bus.req_i[k].amo_op    = t_op;
        bus.req_i[k].size      = 2'($urandom_range(0, 3));
        bus.req_i[k].operand_a = t_a;
        bus.req_i[k].operand_b = t_b;
        bus.req_i[k].req       = 1'b1;
        exp_q[k].push_back(dres(t_op, t_a, t_b));
        pend[k] = 1;
        go[k]--;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    bit idle;
    n = 0;
    idle = 0;
    while (!idle && n < budget) begin
      step();
      n++;
      idle = !m_busy;
      for (int k = 0; k < NP; k++) if (go[k] != 0 || pend[k]) idle = 0;
    end
    if (!idle) chk({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic issue(input int k, input logic [3:0] op, input int n);
    op_sel[k] = int'(op);
    go[k] = n;
  endtask

  initial begin
    gap_max = 0;
    ds_lat  = -1;
    for (int k = 0; k < NP; k++) begin
      op_sel[k] = -1;
      ack_cnt[k] = 0;
    end
    clear_inputs();
    repeat (3) step();
    rst = 1'b0;

    // round-robin from reset: ports 0 and 1 always requesting
    glog.delete();
    issue(0, OP_ADD, 4);
    issue(1, OP_ADD, 4);
    wait_idle(400, "rr");
    chk("rr_len", glog.size(), 8);
    if (glog.size() >= 4) begin
      chk("rr_g0", glog[0], 0);
      chk("rr_g1", glog[1], 1);
      chk("rr_g2", glog[2], 0);
      chk("rr_g3", glog[3], 1);
    end

    // single port, fixed D$ latency, then ack in the first BUSY cycle
    ds_lat = 3;
    issue(0, OP_ADD, 1);
    wait_idle(100, "single");
    ds_lat = 0;
    issue(0, OP_SWAP, 2);
    wait_idle(100, "ack_first_cycle");

    // LR lock held until the owner's SC is acked
    ds_lat = -1;
    glog.delete();
    issue(1, OP_LR, 1);
    wait_idle(100, "lr");
    issue(0, OP_ADD, 1);
    repeat (4) step();
    issue(1, OP_SC, 1);
    wait_idle(200, "lr_sc");
    chk("lr_order_len", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("lr_order_sc", glog[1], 1);
      chk("lr_order_p0", glog[2], 0);
    end

    // lock timeout: LR with no SC, another port waits out the window
    issue(1, OP_LR, 1);
    wait_idle(100, "lr_to");
    issue(0, OP_ADD, 1);
    wait_idle(200, "lock_timeout");

    // request dropped during BUSY, operands scrambled
    ds_lat = 3;
    issue(0, OP_ADD, 1);
    drop_early[0] = 1;
    wait_idle(100, "drop_busy");

    // stray ack while idle
    stray = 1;
    repeat (3) step();

    // randomized mixed traffic
    ds_lat = -1;
    gap_max = 3;
    for (int k = 0; k < NP; k++) issue(k, 4'h0, 30);
    for (int k = 0; k < NP; k++) op_sel[k] = -1;
    wait_idle(20000, "random");
    gap_max = 0;

    // reset in the middle of a transaction
    ds_lat = 10;
    issue(0, OP_ADD, 1);
    issue(1, OP_ADD, 1);
    begin
      int n;
      n = 0;
      while (!m_busy && n < 50) begin
        step();
        n++;
      end
      if (!m_busy) chk("mid_reset_busy_timeout", 1'b0, 1'b1);
    end
    repeat (2) step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_req", bus.amo_req_o.req, 1'b0);
    chk("async_rst_busy", bus.busy_o, 1'b0);
    for (int k = 0; k < NP; k++) chk("async_rst_ack", bus.resp_o[k].ack, 1'b0);
    clear_inputs();
    repeat (2) step();
    rst = 1'b0;
    ds_lat = -1;
    glog.delete();
    issue(1, OP_ADD, 1);
    issue(0, OP_ADD, 1);
    wait_idle(200, "post_reset");
    chk("post_reset_len", glog.size(), 2);
    if (glog.size() >= 1) chk("post_reset_first", glog[0], 0);

    for (int k = 0; k < NP; k++) chk("scoreboard_drained", exp_q[k].size(), 0);
    chk("grant_q_drained", grant_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/amo_arbiter.md
# amo_arbiter

Shares the single cache-subsystem AMO port between `NR_PORTS` AMO requesters, for example several `amo_buffer` instances or a core plus an accelerator. Arbitration is round-robin. The request of the winning port is latched, and the grant is held until the cache acknowledges. After an LR, the LR's port keeps exclusive access for a bounded window so its following SC is not starved. The block sits between the requesters' `ariane_pkg::amo_req_t`/`amo_resp_t` interfaces and the D$ AMO port.

## Interface
- `NR_PORTS`, default 2: number of requesters, at least 2.
- `LR_LOCK_CYCLES`, default 16: length of the exclusive window after an LR ack, in cycles; at least 1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  `[NR_PORTS-1:0]` `amo_req_t`  per-port requests. Fields: `req`, `amo_op`, `size`, `operand_a`, `operand_b`.
- `resp_o`  out  `[NR_PORTS-1:0]` `amo_resp_t`  per-port responses. Fields: `ack`, `result`.
- `amo_req_o`  out  `amo_req_t`  request to the D$.
- `amo_resp_i`  in  `amo_resp_t`  response from the D$.
- `busy_o`  out  1  a transaction is in flight (state BUSY).
- `lock_o`  out  1  the LR exclusive window is active.

## Operation
- **Reset values:** state IDLE; `amo_req_o` all fields 0; `resp_o[*].ack` = 0; `resp_o[*].result` = 0; `busy_o` = 0; `lock_o` = 0; round-robin pointer `rr` = 0; lock counter = 0.
- **FSM state IDLE:**
  - The candidate set is `req_i[k].req` over all ports.
  - If `lock_o` is set, the candidate set is restricted to the lock owner `lk`.
  - The winner is the first candidate at or after `rr`, scanning upward modulo `NR_PORTS`.
  - If a winner `g` exists: register `g`, copy `req_i[g]`'s `amo_op`, `size`, `operand_a` and `operand_b` into the output register, set `amo_req_o.req` = 1, and go to BUSY.
- **FSM state BUSY:**
  - `amo_req_o` is held stable.
  - Changes on `req_i`, including `req` dropping, are ignored. Once issued, an AMO is non-speculative and always completes.
  - When `amo_resp_i.ack` = 1:
    - `resp_o[g].ack` = `amo_resp_i.ack`, combinationally.
    - `amo_req_o.req` is cleared at the edge.
    - `rr` ← (`g`+1) mod `NR_PORTS`.
    - Next state is IDLE.
- **Response routing:**
  - `resp_o[k].result` = `amo_resp_i.result` for all `k`.
  - `resp_o[k].ack` is 0 for every `k`≠`g`, and 0 whenever the state is not BUSY.
- **LR lock:**
  - Opening: on an ack for a granted op of `AMO_LR`, set `lk` = `g`, `lock_o` = 1 and counter = `LR_LOCK_CYCLES`.
  - While `lock_o` is set in IDLE, the counter decrements by 1 per cycle. Reaching 0 clears `lock_o`.
  - Grant to `lk` while locked: the counter freezes. On ack, the lock clears unless the new op is itself `AMO_LR`, in which case the lock is re-armed to `LR_LOCK_CYCLES`.
  - Any SC, or any other AMO, from `lk` releases the lock on its ack.
- **Requester contract:** a requester holds `req` and its fields stable until it sees `ack`, and drops `req` on the following cycle. The arbiter relies on this.

## Timing
- **Issue latency:** `req_i[k].req` rising in cycle t with the arbiter in IDLE gives `amo_req_o.req` = 1 in cycle t+1.
- **Ack latency:** `amo_resp_i.ack` in cycle t gives `resp_o[g].ack` in the same cycle t.
  - State is IDLE in cycle t+1, so a new grant is possible in t+1.
  - A new `amo_req_o.req` can appear in cycle t+2.
- **Back-to-back throughput:** one AMO per 2 cycles plus the D$ latency. At most one AMO is ever in flight.
- **Ack in the first BUSY cycle** (t+1): accepted. `resp_o` acks the same cycle.
- **Stray ack while IDLE:** ignored. No `resp_o` ack is generated and no state changes.
- **Simultaneous events in IDLE:**
  - Lock expiry (counter 1→0) in the same cycle as arbitration: the restriction still applies in that cycle and is gone next cycle.
  - A lock owner with no pending request does not block the other ports' arbitration from ending the window. The other ports stay masked until expiry.
- **Reset mid-transaction:** everything returns to reset values at once, and `amo_req_o.req` drops asynchronously. The D$ side must be reset together with the arbiter.
- **Width rules:**
  - `rr`, `g` and `lk` are `$clog2(NR_PORTS)` bits; when `NR_PORTS` is a power of two, the increment wraps naturally.
  - The counter is `$clog2(LR_LOCK_CYCLES+1)` bits.

## Test plan
- **Single port:** port 0 requests `AMO_ADD`, operand_a=0x80, operand_b=5; D$ acks 3 cycles after `amo_req_o.req` with result=7. Required: `amo_req_o.req` at t+1; `resp_o[0].ack` and result=7 in the ack cycle; `busy_o` falls the next cycle.
- **Round-robin:** ports 0 and 1 request continuously from reset. Required: grant order 0,1,0,1, and `amo_req_o.operand_a` matches the granted port each time.
- **LR lock:** port 1 issues LR and is acked; port 0 requests in the next cycle; port 1 issues SC 4 cycles later. Required: port 0 is not granted until the SC is acked; `lock_o` stays high until the SC ack.
- **Lock timeout:** `LR_LOCK_CYCLES`=16; port 1 issues LR and never issues SC; port 0 requests. Required: port 0 is granted exactly 16 IDLE cycles after the LR ack; `lock_o` falls in that cycle.
- **Request drop during BUSY:** port 0 deasserts `req` during BUSY. Required: `amo_req_o` stays unchanged and `resp_o[0].ack` is still issued on the D$ ack.
- **Reset mid-operation:** `rst_i` asserted during BUSY. Required: outputs return to reset values immediately; after release, the first grant goes to port 0.
